// File: rtl/secuenciador_dispensa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dispensador_pkg
//  Purpose  : Shared FSM state encoding and default timing for the dispenser.
//  Revision : 1.0 - initial release
// ============================================================================
package dispensador_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSA = 2'd1,
        FRENO    = 2'd2,
        FIN      = 2'd3
    } estado_t;

    localparam logic [15:0] c_timeout_ciclos_def = 16'd50000;
    localparam logic [7:0]  c_freno_ciclos_def   = 8'd100;

endpackage
`default_nettype wire

// File: rtl/secuenciador_dispensa_detector.sv
`default_nettype none
// ============================================================================
//  Module   : detector_flanco
//  Purpose  : Two-flop synchronizer followed by a rising-edge detector.
//  Revision : 1.0 - initial release
// ============================================================================
module detector_flanco (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic pulso
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Built only from flops, so the consumer sees a clean one-cycle strobe.
    assign pulso = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/secuenciador_dispensa.sv
`default_nettype none
// ============================================================================
//  Module   : secuenciador_dispensa
//  Purpose  : Portion dispensing sequencer with sensor timeout, abort and
//             motor brake interval before the next job.
//  Revision : 1.0 - initial release
// ============================================================================
module secuenciador_dispensa
    import dispensador_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CICLOS = c_timeout_ciclos_def,
    parameter logic [7:0]  FRENO_CICLOS   = c_freno_ciclos_def
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] cantidad,
    input  logic       abortar,
    input  logic       sensor,
    output logic       motor_on,
    output logic       ocupado,
    output logic [3:0] cuenta,
    output logic       fin,
    output logic       err_timeout,
    output logic       err_abort
);

    estado_t     r_estado;
    logic [3:0]  r_objetivo;
    logic [15:0] r_timer;
    logic [7:0]  r_freno;
    logic        w_pulso;
    logic [3:0]  w_cuenta_sig;

    detector_flanco u_detector (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (sensor),
        .pulso   (w_pulso)
    );

    assign w_cuenta_sig = cuenta + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado    <= IDLE;
            r_objetivo  <= 4'd0;
            r_timer     <= 16'd0;
            r_freno     <= 8'd0;
            motor_on    <= 1'b0;
            ocupado     <= 1'b0;
            cuenta      <= 4'd0;
            fin         <= 1'b0;
            err_timeout <= 1'b0;
            err_abort   <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (r_estado)
                IDLE: begin
                    if (start) begin
                        cuenta      <= 4'd0;
                        err_timeout <= 1'b0;
                        err_abort   <= 1'b0;
                        r_timer     <= 16'd0;
                        ocupado     <= 1'b1;
                        if (cantidad != 4'd0) begin
                            r_objetivo <= cantidad;
                            motor_on   <= 1'b1;
                            r_estado   <= DISPENSA;
                        end else begin
                            r_estado   <= FIN;
                        end
                    end
                end

                DISPENSA: begin
                    if (w_pulso) begin
                        // A portion edge always counts; completion beats abort.
                        cuenta  <= w_cuenta_sig;
                        r_timer <= 16'd0;
                        if (w_cuenta_sig == r_objetivo) begin
                            motor_on <= 1'b0;
                            r_freno  <= 8'd0;
                            r_estado <= FRENO;
                        end else if (abortar) begin
                            err_abort <= 1'b1;
                            motor_on  <= 1'b0;
                            r_freno   <= 8'd0;
                            r_estado  <= FRENO;
                        end
                    end else if (abortar) begin
                        err_abort <= 1'b1;
                        motor_on  <= 1'b0;
                        r_freno   <= 8'd0;
                        r_estado  <= FRENO;
                    end else if (r_timer == TIMEOUT_CICLOS - 16'd1) begin
                        err_timeout <= 1'b1;
                        motor_on    <= 1'b0;
                        r_freno     <= 8'd0;
                        r_estado    <= FRENO;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                FRENO: begin
                    motor_on <= 1'b0;
                    if (r_freno == FRENO_CICLOS - 8'd1) begin
                        r_estado <= FIN;
                    end else begin
                        r_freno <= r_freno + 8'd1;
                    end
                end

                FIN: begin
                    fin      <= 1'b1;
                    ocupado  <= 1'b0;
                    r_estado <= IDLE;
                end

                default: begin
                    motor_on <= 1'b0;
                    ocupado  <= 1'b0;
                    r_estado <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_dispensa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_secuenciador_dispensa
//  Purpose  : Self-checking bench: cycle table, directed jobs, random jobs
//             checked against a job-level event model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_secuenciador_dispensa;

    localparam int c_tmo   = 20;
    localparam int c_freno = 4;
    localparam int c_lat   = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] cantidad = 4'd0;
    logic       abortar = 1'b0;
    logic       sensor = 1'b0;
    logic       motor_on;
    logic       ocupado;
    logic [3:0] cuenta;
    logic       fin;
    logic       err_timeout;
    logic       err_abort;

    int n_pass = 0;
    int n_total = 0;
    int sched[20];

    typedef struct {
        logic       start;
        logic [3:0] cant;
        logic       sensor;
        logic       abortar;
        logic       motor;
        logic       ocup;
        logic [3:0] cuenta;
        logic       fin;
    } vec_t;

    vec_t tab[17];

    secuenciador_dispensa #(
        .TIMEOUT_CICLOS (16'd20),
        .FRENO_CICLOS   (8'd4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cantidad    (cantidad),
        .abortar     (abortar),
        .sensor      (sensor),
        .motor_on    (motor_on),
        .ocupado     (ocupado),
        .cuenta      (cuenta),
        .fin         (fin),
        .err_timeout (err_timeout),
        .err_abort   (err_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    // Job-level model: pulse i is registered c_lat cycles after it is driven;
    // the job ends at the first of completion, abort or a 20-cycle silence.
    task automatic model(input int q, input int np, input int ab,
                         output int x, output int cnt, output bit et, output bit ea);
        int  l;
        int  e;
        int  tmo;
        bit  done;
        x = 0; cnt = 0; et = 0; ea = 0; l = 0; done = 0;
        for (int i = 0; i < np && !done; i++) begin
            e   = sched[i] + c_lat;
            tmo = l + c_tmo;
            if (ab != 0 && ab < e && ab <= tmo) begin
                x = ab; ea = 1; done = 1;
            end else if (tmo < e) begin
                x = tmo; et = 1; done = 1;
            end else begin
                cnt++;
                l = e;
                if (cnt == q) begin
                    x = e; done = 1;
                end else if (ab == e) begin
                    x = e; ea = 1; done = 1;
                end
            end
        end
        if (!done) begin
            tmo = l + c_tmo;
            if (ab != 0 && ab <= tmo) begin
                x = ab; ea = 1;
            end else begin
                x = tmo; et = 1;
            end
        end
    endtask

    task automatic run_job(input string tag, input int q, input int np, input int ab);
        int x;
        int cnt;
        bit et;
        bit ea;
        int fall_k;
        int fin_k;
        int et_k;
        logic motor0;
        model(q, np, ab, x, cnt, et, ea);
        start = 1'b1;
        cantidad = q[3:0];
        tick();
        start = 1'b0;
        cantidad = 4'd0;
        motor0 = motor_on;
        fall_k = -1; fin_k = -1; et_k = -1;
        for (int c = 0; c < 300 && fin_k < 0; c++) begin
            sensor = 1'b0;
            for (int i = 0; i < np; i++)
                if (c >= sched[i] && c < sched[i] + 2) sensor = 1'b1;
            abortar = (ab != 0 && c >= ab - 1);
            tick();
            if (!motor_on && fall_k < 0) fall_k = c + 1;
            if (err_timeout && et_k < 0) et_k = c + 1;
            if (fin) fin_k = c + 1;
        end
        sensor = 1'b0;
        abortar = 1'b0;
        chk({tag, " motor_on after start"}, motor0, 1);
        chk({tag, " motor_off cycle"}, fall_k, x);
        chk({tag, " fin cycle"}, fin_k, x + c_freno + 1);
        chk({tag, " cuenta"}, cuenta, cnt);
        chk({tag, " err_timeout"}, err_timeout, et);
        chk({tag, " err_abort"}, err_abort, ea);
        if (et) chk({tag, " err_timeout cycle"}, et_k, x);
        tick();
        chk({tag, " fin one cycle"}, fin, 0);
        repeat (3) tick();
    endtask

    initial begin
        int np;
        int ab;
        int q;
        int fin_cnt;
        int motor_cnt;

        // start, cant, sensor, abortar | motor, ocupado, cuenta, fin
        tab[0]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
        tab[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
        tab[2]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        tab[3]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
        tab[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
        tab[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
        tab[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
        tab[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
        tab[8]  = '{1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
        tab[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
        tab[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        tab[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        tab[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        tab[13] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        tab[14] = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        tab[15] = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1};
        tab[16] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0};

        repeat (3) tick();
        chk("reset motor_on", motor_on, 0);
        chk("reset ocupado", ocupado, 0);
        chk("reset cuenta", cuenta, 0);
        chk("reset fin", fin, 0);
        chk("reset err_timeout", err_timeout, 0);
        chk("reset err_abort", err_abort, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        for (int r = 0; r < 17; r++) begin
            start    = tab[r].start;
            cantidad = tab[r].cant;
            sensor   = tab[r].sensor;
            abortar  = tab[r].abortar;
            tick();
            chk($sformatf("row%0d motor_on", r), motor_on, tab[r].motor);
            chk($sformatf("row%0d ocupado", r), ocupado, tab[r].ocup);
            chk($sformatf("row%0d cuenta", r), cuenta, tab[r].cuenta);
            chk($sformatf("row%0d fin", r), fin, tab[r].fin);
            chk($sformatf("row%0d errors", r), {err_timeout, err_abort}, 0);
        end
        start = 1'b0;
        sensor = 1'b0;
        repeat (4) tick();

        sched[0] = 0; sched[1] = 10; sched[2] = 20;
        run_job("three_pulses", 3, 3, 0);

        sched[0] = 0; sched[1] = 10;
        run_job("timeout", 5, 2, 0);

        sched[0] = 0; sched[1] = 8; sched[2] = 14;
        run_job("abort", 4, 3, 6);

        // Reset in the middle of a job: outputs drop without waiting for a clock.
        start = 1'b1;
        cantidad = 4'd3;
        tick();
        start = 1'b0;
        sensor = 1'b1;
        repeat (2) tick();
        sensor = 1'b0;
        repeat (3) tick();
        chk("mid job cuenta", cuenta, 1);
        chk("mid job motor_on", motor_on, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async reset motor_on", motor_on, 0);
        chk("async reset ocupado", ocupado, 0);
        chk("async reset cuenta", cuenta, 0);
        chk("async reset flags", {fin, err_timeout, err_abort}, 0);
        tick();
        reset_n = 1'b1;
        fin_cnt = 0;
        motor_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fin) fin_cnt++;
            if (motor_on) motor_cnt++;
        end
        chk("no fin after reset", fin_cnt, 0);
        chk("no motor after reset", motor_cnt, 0);
        sched[0] = 2; sched[1] = 9;
        run_job("after_reset", 2, 2, 0);

        for (int j = 0; j < 30; j++) begin
            q  = int'($urandom_range(1, 15));
            np = int'($urandom_range(0, 12));
            sched[0] = int'($urandom_range(0, 5));
            for (int i = 1; i < np; i++)
                sched[i] = sched[i-1] + int'($urandom_range(4, 26));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
            run_job($sformatf("rnd%0d", j), q, np, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/secuenciador_dispensa.md
SECUENCIADOR_DISPENSA -- requirements
Module: secuenciador_dispensa

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 16'd50000, max clk cycles allowed between sensor pulses while dispensing.
REQ-002 Parameter FRENO_CICLOS, default 8'd100, clk cycles the motor is held off after stopping before the next request is accepted.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  one-cycle request to dispense; sampled only in IDLE.
REQ-006 Port cantidad  input  4  number of portions requested; latched on accepted start.
REQ-007 Port abortar  input  1  level; stops an active dispense.
REQ-008 Port sensor  input  1  asynchronous portion sensor; one rising edge per portion.
REQ-009 Port motor_on  output  1  registered gate/motor enable.
REQ-010 Port ocupado  output  1  high in every state except IDLE.
REQ-011 Port cuenta  output  4  portions counted in the current or last job.
REQ-012 Port fin  output  1  one-cycle pulse on job completion.
REQ-013 Port err_timeout  output  1  sticky; job ended by timeout.
REQ-014 Port err_abort  output  1  sticky; job ended by abortar.

Function
REQ-015 sensor SHALL pass through a 2-flop synchronizer; a portion edge is sync=1 with previous sync=0 (3-cycle input-to-edge latency).
REQ-016 FSM states SHALL be IDLE, DISPENSA, FRENO, FIN.
REQ-017 IDLE, start=1, cantidad!=0: next cycle objetivo<=cantidad, cuenta<=0, both err flags<=0, timer<=0, motor_on<=1, state DISPENSA.
REQ-018 IDLE, start=1, cantidad==0: errors cleared, cuenta<=0, motor_on stays 0, state FIN (fin pulses the following cycle).
REQ-019 start outside IDLE SHALL be ignored, not queued.
REQ-020 DISPENSA: each portion edge increments cuenta and clears timer; otherwise timer increments.
REQ-021 DISPENSA: edge making cuenta==objetivo SHALL move to FRENO with motor_on<=0 in the same clock edge.
REQ-022 DISPENSA: timer==TIMEOUT_CICLOS-1 with no edge SHALL set err_timeout, motor_on<=0, go FRENO.
REQ-023 DISPENSA: abortar=1 SHALL set err_abort, motor_on<=0, go FRENO; abortar has priority over a simultaneous timeout; a simultaneous completing edge is still counted and err_abort not set.
REQ-024 Edge and timeout in the same cycle: edge wins, no error.
REQ-025 Portion edges outside DISPENSA SHALL be ignored; cuenta never exceeds objetivo and never wraps.
REQ-026 FRENO: motor_on=0, counts FRENO_CICLOS cycles, then FIN.
REQ-027 FIN: fin=1 for exactly one cycle, then IDLE; cuenta and err flags hold until next accepted start.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, motor_on=0, ocupado=0, cuenta=0, fin=0, err_timeout=0, err_abort=0, timers and synchronizer flops 0, regardless of state.
REQ-030 Reset mid-DISPENSA SHALL drop motor_on without passing through FRENO; no fin is issued for the cut job.

Structure
REQ-031 State encoding and default TIMEOUT/FRENO values SHALL live in shared package dispensador_pkg.
REQ-032 Synchronizer plus rising-edge detect SHALL be sub-module detector_flanco (clk, reset_n, in, pulso).

Verification (TIMEOUT_CICLOS=20, FRENO_CICLOS=4 on bench)
REQ-033 start, cantidad=3, three sensor pulses 10 cycles apart -> motor_on high until third edge registered, cuenta=3, fin one cycle after 4 FRENO cycles, no errors.
REQ-034 start, cantidad=0 -> motor_on never asserted, fin pulses 2 cycles after start, cuenta=0.
REQ-035 start, cantidad=5, 2 pulses then silence -> err_timeout=1 exactly 20 cycles after last edge, cuenta=2, fin follows FRENO.
REQ-036 start, cantidad=4, abortar after 1 pulse -> err_abort=1, motor_on=0 next edge, cuenta=1; extra sensor pulses in FRENO leave cuenta=1.
REQ-037 reset_n low mid-DISPENSA -> all outputs 0 asynchronously; new start afterwards runs normally.
REQ-038 start pulsed while ocupado=1 -> ignored; objetivo and cuenta unchanged.
